// File: rtl/register_stream_reader.sv
// register_stream_reader: walks a register array from a base address and streams the words out on valid/ready.
// Optional feature: define REGISTER_READER_PARITY_EN to add a registered even-parity output for each streamed word.
module register_stream_reader #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRWIDTH     = 4
) (
    input  logic                     RegisterReader_CLOCK,
    input  logic                     RegisterReader_Reset_InLow,
    input  logic                     RegisterReader_Start_InHigh,
    input  logic [ADDRWIDTH-1:0]     RegisterReader_BaseAddr,
    input  logic [ADDRWIDTH:0]       RegisterReader_Length,
    output logic [ADDRWIDTH-1:0]     RegisterReader_Addr,
    input  logic [DATAWIDTH_BUS-1:0] RegisterReader_RdDataBUS,
    output logic [DATAWIDTH_BUS-1:0] RegisterReader_DataOutBUS,
    output logic                     RegisterReader_Valid,
    input  logic                     RegisterReader_Ready,
    output logic                     RegisterReader_Busy,
`ifdef REGISTER_READER_PARITY_EN
    output logic                     RegisterReader_Parity,
    output logic                     RegisterReader_Done
`else
    output logic                     RegisterReader_Done
`endif
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [ADDRWIDTH:0]   DEPTH_W = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH-1:0] LAST    = ADDRWIDTH'(DEPTH - 1);

    state_t               state;
    logic [ADDRWIDTH:0]   remaining;
    logic                 cap;

    // A new word may be captured whenever words remain and the output slot is free or being drained.
    assign cap = (state == STREAM) && (remaining != '0) && (!RegisterReader_Valid || RegisterReader_Ready);

    // Control FSM: accept a request in IDLE, stream words in STREAM, pulse Done on completion.
    always_ff @(posedge RegisterReader_CLOCK) begin
        if (!RegisterReader_Reset_InLow) begin
            state                     <= IDLE;
            remaining                 <= '0;
            RegisterReader_Addr       <= '0;
            RegisterReader_DataOutBUS <= '0;
            RegisterReader_Valid      <= 1'b0;
            RegisterReader_Busy       <= 1'b0;
            RegisterReader_Done       <= 1'b0;
        end else begin
            RegisterReader_Done <= 1'b0;
            if (state == IDLE) begin
                if (RegisterReader_Start_InHigh) begin
                    if (RegisterReader_Length == '0) begin
                        RegisterReader_Done <= 1'b1;
                    end else begin
                        RegisterReader_Addr <= RegisterReader_BaseAddr;
                        remaining           <= (RegisterReader_Length > DEPTH_W) ? DEPTH_W : RegisterReader_Length;
                        state               <= STREAM;
                        RegisterReader_Busy <= 1'b1;
                    end
                end
            end else if (cap) begin
                RegisterReader_DataOutBUS <= RegisterReader_RdDataBUS;
                RegisterReader_Valid      <= 1'b1;
                remaining                 <= remaining - 1'b1;
                RegisterReader_Addr       <= (RegisterReader_Addr == LAST) ? '0 : RegisterReader_Addr + 1'b1;
            end else if (!RegisterReader_Valid || RegisterReader_Ready) begin
                // No capture with a free slot means nothing remains: the last word has just left.
                RegisterReader_Valid <= 1'b0;
                RegisterReader_Busy  <= 1'b0;
                RegisterReader_Done  <= 1'b1;
                state                <= IDLE;
            end
        end
    end

`ifdef REGISTER_READER_PARITY_EN
    // Parity is captured alongside the data word so it holds exactly as DataOutBUS does.
    always_ff @(posedge RegisterReader_CLOCK) begin
        if (!RegisterReader_Reset_InLow) begin
            RegisterReader_Parity <= 1'b0;
        end else if (cap) begin
            RegisterReader_Parity <= ^RegisterReader_RdDataBUS;
        end
    end
`endif

endmodule

// File: tb/tb_register_stream_reader.sv
// tb_register_stream_reader: randomized and directed checks of register_stream_reader against a queue-based model.
module tb_register_stream_reader;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd, dout;
    logic          valid, busy, done;
`ifdef REGISTER_READER_PARITY_EN
    logic          parity;
`endif
    logic [DW-1:0] mem [D];

    assign rd = mem[addr];
    always #5 clk = ~clk;

    register_stream_reader #(.DATAWIDTH_BUS(DW), .DEPTH(D), .ADDRWIDTH(AW)) dut (
        .RegisterReader_CLOCK(clk),
        .RegisterReader_Reset_InLow(rst_n),
        .RegisterReader_Start_InHigh(start),
        .RegisterReader_BaseAddr(base),
        .RegisterReader_Length(len),
        .RegisterReader_Addr(addr),
        .RegisterReader_RdDataBUS(rd),
        .RegisterReader_DataOutBUS(dout),
        .RegisterReader_Valid(valid),
        .RegisterReader_Ready(ready),
        .RegisterReader_Busy(busy),
`ifdef REGISTER_READER_PARITY_EN
        .RegisterReader_Parity(parity),
`endif
        .RegisterReader_Done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words still owed to the consumer plus a few flags.
    bit            active = 0, exp_done = 0, rst_chk = 0, prev_stall = 0, more = 0;
    int            lat = 0, hs_count = 0;
    logic [AW-1:0] exp_addr = '0, pend_addr = '0;
    logic [DW-1:0] q[$], log_q[$];
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        bit hs, was_active;
        int n;
        hs = valid && ready;
        if (rst_chk) begin
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_addr", addr, 0);
            check("rst_data", dout, 0);
        end else begin
            check("busy", busy, active);
            check("done", done, exp_done);
            if (!active) begin
                check("idle_valid", valid, 0);
                check("idle_addr", addr, exp_addr);
            end
            if (lat == 1) check("lat_first", valid, 0);
            if (lat == 2) check("lat_second", valid, 1);
            if (prev_stall) begin
                check("hold_valid", valid, 1);
                check("hold_data", dout, prev_data);
            end
            if (more) check("throughput", valid, 1);
`ifdef REGISTER_READER_PARITY_EN
            if (valid) check("parity", parity, ^dout);
`endif
            if (hs) begin
                check("word_avail", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("word", dout, q.pop_front());
                log_q.push_back(dout);
                hs_count++;
            end
        end
        lat = (lat == 1) ? 2 : 0;
        if (!rst_n) begin
            active = 0; q.delete(); exp_done = 0; exp_addr = '0;
            prev_stall = 0; more = 0; lat = 0; rst_chk = 1;
        end else begin
            rst_chk = 0;
            was_active = active;
            exp_done = 0;
            prev_stall = valid && !ready;
            prev_data = dout;
            more = hs && q.size() != 0;
            if (hs && active && q.size() == 0) begin
                active = 0; exp_done = 1; exp_addr = pend_addr;
            end
            if (!was_active && start) begin
                if (len == 0) exp_done = 1;
                else begin
                    n = (len > D) ? D : int'(len);
                    for (int i = 0; i < n; i++) q.push_back(mem[(base + i) % D]);
                    pend_addr = AW'((base + n) % D);
                    active = 1;
                    lat = 1;
                end
            end
        end
    end

    // Ready patterns: 0 = always ready, 1 = random, 2 = stall three cycles on word 0x12.
    int rmode = 0, stalls = 0;
    always @(posedge clk) begin
        #1;
        if (rmode == 0) ready = 1'b1;
        else if (rmode == 1) ready = ($urandom % 4) != 0;
        else if (valid && dout == 8'h12 && stalls < 3) begin
            ready = 1'b0;
            stalls++;
        end else ready = 1'b1;
    end

    task automatic xfer(input int b, input int l);
        log_q.delete();
        @(posedge clk) #1;
        base = AW'(b); len = (AW + 1)'(l); start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        for (int c = 0; c < 400 && (active || exp_done); c++) @(posedge clk) #1;
        check("xfer_timeout", 32'(active || exp_done), 0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < D; i++) mem[i] = DW'(8'h10 + i);
    endtask

    initial begin
        int h0;
        fill_ramp();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Base 3, four words, always ready.
        xfer(3, 4);
        check("t1_count", log_q.size(), 4);
        for (int i = 0; i < log_q.size(); i++) check("t1_word", log_q[i], 8'h13 + i);
        check("t1_busy", busy, 0);
        // Wrap from entry 15 back to 0.
        xfer(14, 4);
        check("t2_count", log_q.size(), 4);
        for (int i = 0; i < log_q.size(); i++) check("t2_word", log_q[i], (8'h1E + i) & 8'h1F | 8'h10);
        check("t2_addr", addr, 2);
        // Three-cycle stall on 0x12.
        rmode = 2; stalls = 0;
        xfer(0, 6);
        check("t3_stalls", stalls, 3);
        check("t3_count", log_q.size(), 6);
        for (int i = 0; i < log_q.size(); i++) check("t3_word", log_q[i], 8'h10 + i);
        rmode = 0;
        // Zero length, then oversize length saturating to the array depth.
        xfer(7, 0);
        check("t4_zero_count", log_q.size(), 0);
        xfer(0, 20);
        check("t4_sat_count", log_q.size(), 16);
        for (int i = 0; i < log_q.size(); i++) check("t4_word", log_q[i], 8'h10 + i);
        // Reset after the second handshake of an eight-word transfer.
        h0 = hs_count;
        @(posedge clk) #1;
        base = '0; len = 6'd8; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        for (int c = 0; c < 50 && hs_count < h0 + 2; c++) @(posedge clk) #1;
        check("t5_reach", hs_count - h0, 2);
        rst_n = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_valid", valid, 0);
        check("t5_addr", addr, 0);
        xfer(5, 2);
        check("t5_count", log_q.size(), 2);
        for (int i = 0; i < log_q.size(); i++) check("t5_word", log_q[i], 8'h15 + i);
        // Single-word transfers leave the word on the bus for inspection.
        xfer(3, 1);
        check("t6_word13", dout, 8'h13);
`ifdef REGISTER_READER_PARITY_EN
        check("t6_par13", parity, 1);
`endif
        xfer(1, 1);
        check("t6_word11", dout, 8'h11);
`ifdef REGISTER_READER_PARITY_EN
        check("t6_par11", parity, 0);
`endif
        // Randomized transfers over random array contents and random backpressure.
        rmode = 1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < D; i++) mem[i] = DW'($urandom);
            rmode = (t % 5 == 0) ? 0 : 1;
            xfer($urandom % 16, $urandom % 21);
        end
        rmode = 0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/register_stream_reader.md
Name: register_stream_reader

Overview:
- Read-side companion to the load-enabled data registers used in the CNN datapath.
- Walks a DEPTH-entry register array through an address output and samples its asynchronous read data.
- Emits the words in order on a registered valid/ready stream for the downstream MAC/convolution stage.
- Software-style control: a start pulse with a base address and a word count; one done pulse at the end.

Parameters:
DATAWIDTH_BUS, 8, width of each register word and of the output stream
DEPTH, 16, number of entries in the register array being read
ADDRWIDTH, 4, address width; must satisfy 2**ADDRWIDTH >= DEPTH

Ports:
RegisterReader_CLOCK  input  1  single clock; all state changes on its rising edge
RegisterReader_Reset_InLow  input  1  reset, synchronous, active-low
RegisterReader_Start_InHigh  input  1  start request, sampled only in IDLE
RegisterReader_BaseAddr  input  ADDRWIDTH  first entry to read, sampled with Start
RegisterReader_Length  input  ADDRWIDTH+1  words to read, sampled with Start
RegisterReader_Addr  output  ADDRWIDTH  read address driven to the register array
RegisterReader_RdDataBUS  input  DATAWIDTH_BUS  combinational read data of the array at RegisterReader_Addr
RegisterReader_DataOutBUS  output  DATAWIDTH_BUS  stream data
RegisterReader_Valid  output  1  stream data valid
RegisterReader_Ready  input  1  downstream accepts the current word
RegisterReader_Busy  output  1  high while in STREAM
RegisterReader_Done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset (Reset_InLow=0 at a clock edge): state=IDLE, Addr=0, DataOutBUS=0, Valid=0, Busy=0, Done=0, remaining=0.
- Reset mid-transfer aborts the transfer. The pending word is dropped and no Done is issued.
- All outputs are registered.
- States: IDLE, STREAM.
- IDLE, Start=1, Length!=0:
  - Addr<=BaseAddr.
  - remaining<=min(Length, DEPTH); values above DEPTH saturate to DEPTH.
  - Go to STREAM; Busy<=1.
- IDLE, Start=1, Length=0: stay IDLE, Done<=1 for one cycle, Valid never asserts.
- Start while in STREAM is ignored.
- Handshake: a word transfers on an edge where Valid=1 and Ready=1.
- DataOutBUS is held stable while Valid=1 and Ready=0. Valid never drops without a handshake.
- STREAM, capture condition cap = (remaining!=0) and (Valid=0 or Ready=1). On cap:
  - DataOutBUS<=RdDataBUS (the array word at the current Addr).
  - Valid<=1, remaining<=remaining-1.
  - Addr<=Addr+1; Addr wraps from DEPTH-1 to 0.
- STREAM, no cap, Valid=1 and Ready=1: Valid<=0.
- STREAM completion: when remaining=0 and the last word is handshaked (or Valid=0):
  - Go to IDLE, Busy<=0.
  - Done<=1 for exactly one cycle, in the cycle after the final handshake.
- Latency: Start sampled at edge k, Valid first high after edge k+1.
- Throughput: one word per cycle while Ready is held high.
- Addr holds its last value in IDLE (one past the last word read, wrapped).
- Word order is strictly BaseAddr, BaseAddr+1, ... mod DEPTH. No word is duplicated or skipped under any Ready pattern.

Optional Feature:
REGISTER_READER_PARITY_EN
- Defined: adds output RegisterReader_Parity (1 bit).
  - Even parity (XOR) of the captured word, registered together with DataOutBUS.
  - Same hold/reset rules as DataOutBUS; reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
All scenarios use DEPTH=16, DATAWIDTH_BUS=8, array entry i = 0x10+i.
1. Base=3, Length=4, Ready=1: Valid high 4 consecutive cycles starting 2 edges after Start, data 0x13,0x14,0x15,0x16; Done one cycle after the last handshake; Busy low afterwards.
2. Base=14, Length=4, Ready=1 (wrap): data 0x1E,0x1F,0x10,0x11; Addr ends at 2.
3. Base=0, Length=6, Ready low for 3 cycles while word 0x12 is valid: 0x12 held stable and Valid stays high; full sequence is 0x10..0x15 with no duplicates or gaps.
4. Length=0 Start: no Valid; Done high exactly one cycle after Start; Busy never high. Length=20: exactly 16 words, 0x10..0x1F.
5. Reset_InLow=0 for one edge after the second handshake of a Length=8 run: next cycle Valid=0, Busy=0, Addr=0, Done=0. A following Start with Base=5, Length=2 yields 0x15,0x16.
6. With REGISTER_READER_PARITY_EN, word 0x13: Parity=1; word 0x11: Parity=0; Parity held while stalled.
